datapath_param: RTL and testbench

- Parametrised successor of the team's register-file/ALU datapath.
- An input bus of NB_IN lanes, each DATA_W bits wide, feeds a lane selector that writes into an NB_REGS-entry register file.
- Two read ports feed an 8-op ALU. The result can be written back into the register file or presented on a registered output with a registered flag.
- Sits between the input capture logic and the display/output stage; it is the formal-verification target for the next lab.

---
 rtl/datapath_param.sv | 127 ++++++++++++
 tb/tb_datapath_param.sv | 134 +++++++++++++
 2 files changed

// File: rtl/datapath_param.sv
// Parametrised register-file/ALU datapath: lane-selected or ALU write-back into
// an NB_REGS-entry file, two combinational read ports, registered result and flag.
module datapath_param #(
   parameter int DATA_W  = 8,
   parameter int NB_IN   = 8,
   parameter int NB_REGS = 16,
   parameter int OUT_W   = 7
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NB_IN*DATA_W-1:0]      InPort,
   input  logic [((NB_IN > 1) ? $clog2(NB_IN) : 1)-1:0]     Sel,
   input  logic                         Wen,
   input  logic                         WSrc,
   input  logic [((NB_REGS > 1) ? $clog2(NB_REGS) : 1)-1:0] WA,
   input  logic [((NB_REGS > 1) ? $clog2(NB_REGS) : 1)-1:0] RAA,
   input  logic [((NB_REGS > 1) ? $clog2(NB_REGS) : 1)-1:0] RAB,
   input  logic [2:0]                   Op,
   output logic [OUT_W-1:0]             OutPort,
   output logic                         Flag
);

   localparam int SEL_W = (NB_IN > 1) ? $clog2(NB_IN) : 1;
   localparam int AW    = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
   localparam logic [AW:0]    NB_REGS_L = (AW+1)'(NB_REGS);
   localparam logic [SEL_W:0] NB_IN_L   = (SEL_W+1)'(NB_IN);
   localparam logic [DATA_W-1:0] ZERO   = {DATA_W{1'b0}};

   logic [DATA_W-1:0] regs_q [NB_REGS];
   logic [DATA_W-1:0] lanes_s [NB_IN];
   logic [DATA_W-1:0] lane_s;
   logic [DATA_W-1:0] a_s;
   logic [DATA_W-1:0] b_s;
   logic [DATA_W:0]   sum_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              alu_c_s;
   logic [DATA_W-1:0] wdata_s;
   logic [OUT_W-1:0]  out_d;
   logic [OUT_W-1:0]  out_q;
   logic              flag_d;
   logic              flag_q;

   for (genvar g = 0; g < NB_IN; g++) begin : g_lane
      assign lanes_s[g] = InPort[g*DATA_W +: DATA_W];
   end

   // Lane selection and read ports; out-of-range indices yield zero
   always_comb begin
      lane_s = ZERO;
      a_s    = ZERO;
      b_s    = ZERO;
      if ({1'b0, Sel} < NB_IN_L) begin
         lane_s = lanes_s[Sel];
      end else begin
         lane_s = ZERO;
      end
      if ({1'b0, RAA} < NB_REGS_L) begin
         a_s = regs_q[RAA];
      end else begin
         a_s = ZERO;
      end
      if ({1'b0, RAB} < NB_REGS_L) begin
         b_s = regs_q[RAB];
      end else begin
         b_s = ZERO;
      end
   end

   // ALU: arithmetic ops report carry/borrow, logic ops report a zero result
   always_comb begin
      sum_s     = {1'b0, a_s} + {1'b0, b_s};
      alu_res_s = ZERO;
      alu_c_s   = 1'b0;
      case (Op)
         3'd0: begin
            alu_res_s = sum_s[DATA_W-1:0];
            alu_c_s   = sum_s[DATA_W];
         end
         3'd1: begin
            alu_res_s = a_s - b_s;
            alu_c_s   = (a_s < b_s);
         end
         3'd2:    alu_res_s = a_s & b_s;
         3'd3:    alu_res_s = a_s | b_s;
         3'd4:    alu_res_s = a_s;
         3'd5:    alu_res_s = b_s;
         3'd6:    alu_res_s = a_s ^ b_s;
         3'd7:    alu_res_s = ~a_s;
         default: alu_res_s = ZERO;
      endcase
      if ((Op == 3'd0) || (Op == 3'd1)) begin
         flag_d = alu_c_s;
      end else begin
         flag_d = (alu_res_s == ZERO);
      end
      out_d   = alu_res_s[OUT_W-1:0];
      wdata_s = WSrc ? alu_res_s : lane_s;
   end

   // Register file: no bypass, so writes become visible on the following cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB_REGS; i++) begin
         if (rst) begin
            regs_q[i] <= ZERO;
         end else if (Wen && (WA == AW'(i))) begin
            regs_q[i] <= wdata_s;
         end else begin
            regs_q[i] <= regs_q[i];
         end
      end
   end

   // Output stage follows the ALU with one cycle of latency
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= {OUT_W{1'b0}};
         flag_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         flag_q <= flag_d;
      end
   end

   assign OutPort = out_q;
   assign Flag    = flag_q;

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param with hand-computed expected values.
module tb_datapath_param;

   logic        clk;
   logic        rst;
   logic [63:0] InPort;
   logic [2:0]  Sel;
   logic        Wen;
   logic        WSrc;
   logic [3:0]  WA;
   logic [3:0]  RAA;
   logic [3:0]  RAB;
   logic [2:0]  Op;
   logic [6:0]  OutPort;
   logic        Flag;

   int vectors;
   int miscompares;

   datapath_param dut (
      .clk(clk), .rst(rst), .InPort(InPort), .Sel(Sel), .Wen(Wen), .WSrc(WSrc),
      .WA(WA), .RAA(RAA), .RAB(RAB), .Op(Op), .OutPort(OutPort), .Flag(Flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [6:0] exp_out, input logic exp_flag);
      vectors++;
      assert (OutPort === exp_out) else begin
         miscompares++;
         $error("FAIL %s OutPort: got %h expected %h", tag, OutPort, exp_out);
      end
      vectors++;
      assert (Flag === exp_flag) else begin
         miscompares++;
         $error("FAIL %s Flag: got %b expected %b", tag, Flag, exp_flag);
      end
   endtask

   task automatic lane_write(input logic [63:0] bus, input logic [2:0] s, input logic [3:0] a);
      InPort = bus; Sel = s; WA = a; Wen = 1'b1; WSrc = 1'b0;
      tick();
      Wen = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; InPort = 64'h0; Sel = 3'd0; Wen = 1'b0; WSrc = 1'b0;
      WA = 4'd0; RAA = 4'd0; RAB = 4'd0; Op = 3'd4;
      tick(); tick();
      check("reset", 7'h00, 1'b0);

      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         RAA = 4'(i);
         tick();
         check("idle_sweep", 7'h00, 1'b1);
      end

      lane_write(64'h0706050403020100, 3'd3, 4'd5);
      Op = 3'd4; RAA = 4'd5;
      tick();
      check("lane_read", 7'h03, 1'b0);

      lane_write(64'h00000000000020F0, 3'd0, 4'd1);
      lane_write(64'h00000000000020F0, 3'd1, 4'd2);
      Op = 3'd0; RAA = 4'd1; RAB = 4'd2; Wen = 1'b1; WSrc = 1'b1; WA = 4'd3;
      tick();
      Wen = 1'b0;
      check("add_carry", 7'h10, 1'b1);
      Op = 3'd4; RAA = 4'd3;
      tick();
      check("add_wb", 7'h10, 1'b0);

      // write-back into the register being read: ALU sees old 0x10
      Op = 3'd0; RAA = 4'd3; RAB = 4'd3; Wen = 1'b1; WSrc = 1'b1; WA = 4'd3;
      tick();
      Wen = 1'b0;
      check("self_wb", 7'h20, 1'b0);
      Op = 3'd4; RAA = 4'd3;
      tick();
      check("self_wb_read", 7'h20, 1'b0);

      Op = 3'd1; RAA = 4'd2; RAB = 4'd1;
      tick();
      check("sub_borrow", 7'h30, 1'b1);
      RAA = 4'd1; RAB = 4'd2;
      tick();
      check("sub_noborrow", 7'h50, 1'b0);

      Op = 3'd2; tick(); check("and", 7'h20, 1'b0);
      Op = 3'd3; tick(); check("or", 7'h70, 1'b0);
      Op = 3'd6; tick(); check("xor", 7'h50, 1'b0);
      Op = 3'd5; tick(); check("passb", 7'h20, 1'b0);
      Op = 3'd6; RAB = 4'd1; tick(); check("xor_zero", 7'h00, 1'b1);
      Op = 3'd0; RAA = 4'd2; RAB = 4'd2; tick(); check("add_nocarry", 7'h40, 1'b0);

      lane_write(64'h00000000000000FF, 3'd0, 4'd4);
      Op = 3'd4; RAA = 4'd4;
      tick();
      check("trunc", 7'h7F, 1'b0);
      Op = 3'd7;
      tick();
      check("nota", 7'h00, 1'b1);

      // read-during-write returns the old value; new value shows two edges later
      Op = 3'd4; RAA = 4'd7;
      lane_write(64'h0000000000000055, 3'd0, 4'd7);
      check("rdw_old", 7'h00, 1'b1);
      tick();
      check("rdw_new", 7'h55, 1'b0);

      InPort = 64'h0000000000AA0000; Sel = 3'd2; WA = 4'd6; Wen = 1'b1; WSrc = 1'b0;
      rst = 1'b1; Op = 3'd4; RAA = 4'd4;
      tick();
      check("rst_mid", 7'h00, 1'b0);
      rst = 1'b0; Wen = 1'b0; RAA = 4'd6;
      tick();
      check("rst_drop", 7'h00, 1'b1);
      RAA = 4'd1;
      tick();
      check("rst_clear", 7'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
